// File: rtl/landrover.sv
`default_nettype none
// ============================================================================
// Module   : landrover
// Purpose  : Moore FSM detecting the serial pattern 1-0-1-1-0 (overlapping),
//            with registered detect flag and saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module landrover #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             X,
    output logic [2:0]       state,
    output logic             detect,
    output logic [CNT_W-1:0] det_count
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100,
        S5 = 3'b101
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    // Held as a plain vector so the illegal codes 110/111 are representable.
    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_detect;
    logic [CNT_W-1:0] r_count;
    logic             w_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S0;
            r_detect <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_next;
            r_detect <= w_hit;
            if (w_hit && (r_count != C_CNT_MAX)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = X ? S1 : S0;
            S1:      w_next = X ? S1 : S2;
            S2:      w_next = X ? S3 : S0;
            S3:      w_next = X ? S4 : S2;
            S4:      w_next = X ? S1 : S5;
            S5:      w_next = X ? S3 : S0;
            default: w_next = S0;
        endcase
    end

    // detect is registered alongside the state, so it equals (state == S5).
    assign w_hit     = (w_next == S5);
    assign state     = r_state;
    assign detect    = r_detect;
    assign det_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_landrover.sv
`default_nettype none
// ============================================================================
// Module   : tb_landrover
// Purpose  : Directed self-checking bench for landrover using a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_landrover;

    logic       clk;
    logic       reset;
    logic       X;
    logic [2:0] state;
    logic       detect;
    logic [7:0] det_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // {state, detect, det_count}
    logic [11:0] sb_q[$];

    landrover #(.CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .X         (X),
        .state     (state),
        .detect    (detect),
        .det_count (det_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

    task automatic compare(input string tag);
        logic [11:0] exp_v;
        logic [11:0] obs_v;
        exp_v = sb_q.pop_front();
        obs_v = {state, detect, det_count};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed state=%b det=%b cnt=%0d expected state=%b det=%b cnt=%0d",
                   tag, obs_v[11:9], obs_v[8], obs_v[7:0], exp_v[11:9], exp_v[8], exp_v[7:0]);
        end
    endtask

    // Drive one bit away from the edge, then check the result after the edge.
    task automatic step(input logic x, input logic [2:0] es, input logic ed,
                        input logic [7:0] ec, input string tag);
        @(negedge clk);
        X = x;
        sb_q.push_back({es, ed, ec});
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic check_now(input logic [2:0] es, input logic ed,
                             input logic [7:0] ec, input string tag);
        sb_q.push_back({es, ed, ec});
        compare(tag);
    endtask

    initial begin
        logic [7:0] exp_cnt;
        reset = 1'b0;
        X     = 1'b0;

        // Reset held with X toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            X = ~X;
            @(posedge clk);
            #1;
            check_now(3'b000, 1'b0, 8'd0, "reset_hold");
        end

        @(negedge clk);
        reset = 1'b1;

        // First match 10110
        step(1'b1, 3'b001, 1'b0, 8'd0, "m1_b1");
        step(1'b0, 3'b010, 1'b0, 8'd0, "m1_b2");
        step(1'b1, 3'b011, 1'b0, 8'd0, "m1_b3");
        step(1'b1, 3'b100, 1'b0, 8'd0, "m1_b4");
        step(1'b0, 3'b101, 1'b1, 8'd1, "m1_b5");

        // Overlapping match from S5
        step(1'b1, 3'b011, 1'b0, 8'd1, "ov_b1");
        step(1'b1, 3'b100, 1'b0, 8'd1, "ov_b2");
        step(1'b0, 3'b101, 1'b1, 8'd2, "ov_b3");

        // S5 exits to S0 on 0, then a run of ones stays in S1
        step(1'b0, 3'b000, 1'b0, 8'd2, "s5_to_s0");
        for (int i = 0; i < 4; i++)
            step(1'b1, 3'b001, 1'b0, 8'd2, "ones");

        // S1 on 0, S2 on 0 back to S0, S4 on 1 to S1, S3 on 0 to S2
        step(1'b0, 3'b010, 1'b0, 8'd2, "s1_0");
        step(1'b0, 3'b000, 1'b0, 8'd2, "s2_0");
        step(1'b1, 3'b001, 1'b0, 8'd2, "p_b1");
        step(1'b0, 3'b010, 1'b0, 8'd2, "p_b2");
        step(1'b1, 3'b011, 1'b0, 8'd2, "p_b3");
        step(1'b0, 3'b010, 1'b0, 8'd2, "s3_0");
        step(1'b1, 3'b011, 1'b0, 8'd2, "p_b3b");
        step(1'b1, 3'b100, 1'b0, 8'd2, "p_b4");
        step(1'b1, 3'b001, 1'b0, 8'd2, "s4_1");

        // Reset mid-pattern, between edges
        step(1'b0, 3'b010, 1'b0, 8'd2, "mid_b2");
        step(1'b1, 3'b011, 1'b0, 8'd2, "mid_b3");
        step(1'b1, 3'b100, 1'b0, 8'd2, "mid_b4");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_now(3'b000, 1'b0, 8'd0, "async_reset");
        @(negedge clk);
        X = 1'b0;
        reset = 1'b1;
        step(1'b1, 3'b001, 1'b0, 8'd0, "post_reset");
        step(1'b0, 3'b010, 1'b0, 8'd0, "post_reset_b2");
        step(1'b1, 3'b011, 1'b0, 8'd0, "post_reset_b3");
        step(1'b1, 3'b100, 1'b0, 8'd0, "post_reset_b4");

        // Reset coincident with a clock edge: reset wins over X=0 -> S5
        @(negedge clk);
        X = 1'b0;
        @(posedge clk);
        reset = 1'b0;
        #1;
        check_now(3'b000, 1'b0, 8'd0, "reset_at_edge");
        @(negedge clk);
        reset = 1'b1;

        // Illegal codes return to S0 for either X
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            X = i[0];
            force dut.r_state = (i < 2) ? 3'b110 : 3'b111;
            #1;
            release dut.r_state;
            #1;
            check_now((i < 2) ? 3'b110 : 3'b111, 1'b0, 8'd0, "illegal_hold");
            @(posedge clk);
            #1;
            check_now(3'b000, 1'b0, 8'd0, "illegal_exit");
        end

        // 256 back-to-back matches: counter saturates at 255
        exp_cnt = 8'd0;
        step(1'b1, 3'b001, 1'b0, exp_cnt, "sat_b1");
        step(1'b0, 3'b010, 1'b0, exp_cnt, "sat_b2");
        step(1'b1, 3'b011, 1'b0, exp_cnt, "sat_b3");
        step(1'b1, 3'b100, 1'b0, exp_cnt, "sat_b4");
        exp_cnt = 8'd1;
        step(1'b0, 3'b101, 1'b1, exp_cnt, "sat_b5");
        for (int k = 2; k <= 256; k++) begin
            step(1'b1, 3'b011, 1'b0, exp_cnt, "sat_ov1");
            step(1'b1, 3'b100, 1'b0, exp_cnt, "sat_ov2");
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            step(1'b0, 3'b101, 1'b1, exp_cnt, "sat_ov3");
        end
        step(1'b0, 3'b000, 1'b0, 8'd255, "sat_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
